// File: rtl/fmul_sched_pkg.sv
// Shared constants and types for the two-port fmul scheduler.
package fmul_sched_pkg;

  localparam int unsigned NumPorts = 2;
  localparam int unsigned FloatW   = 32;

  typedef logic [0:0] port_id_t;

endpackage

// File: rtl/fmul_sched_fmul.sv
// IEEE-754 single-precision multiplier with one registered output stage.
// Round-to-nearest-even; subnormal inputs and results are flushed to signed zero.
module fmul_sched_fmul
  import fmul_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [FloatW-1:0] i_x1,
  input  logic [FloatW-1:0] i_x2,
  output logic [FloatW-1:0] o_y
);

  logic              w_sign, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic              w_guard, w_sticky;
  logic [47:0]       w_prod;
  logic [22:0]       w_frac;
  logic [23:0]       w_mant;
  logic signed [9:0] w_exp;
  logic [FloatW-1:0] w_res;

  always_comb begin
    w_sign   = i_x1[31] ^ i_x2[31];
    w_nan_a  = (i_x1[30:23] == 8'hFF) && (i_x1[22:0] != '0);
    w_nan_b  = (i_x2[30:23] == 8'hFF) && (i_x2[22:0] != '0);
    w_inf_a  = (i_x1[30:23] == 8'hFF) && (i_x1[22:0] == '0);
    w_inf_b  = (i_x2[30:23] == 8'hFF) && (i_x2[22:0] == '0);
    w_zero_a = (i_x1[30:23] == 8'h00);
    w_zero_b = (i_x2[30:23] == 8'h00);
    w_prod   = 48'({1'b1, i_x1[22:0]}) * 48'({1'b1, i_x2[22:0]});
    w_exp    = $signed(10'(i_x1[30:23]) + 10'(i_x2[30:23]) - 10'd127);
    // Product of two 1.x mantissas lies in [1,4); normalise the [2,4) case.
    if (w_prod[47]) begin
      w_frac   = w_prod[46:24];
      w_guard  = w_prod[23];
      w_sticky = |w_prod[22:0];
      w_exp    = w_exp + 10'sd1;
    end else begin
      w_frac   = w_prod[45:23];
      w_guard  = w_prod[22];
      w_sticky = |w_prod[21:0];
    end
    w_mant = {1'b0, w_frac} + 24'(w_guard & (w_sticky | w_frac[0]));
    if (w_mant[23]) begin
      w_exp = w_exp + 10'sd1;
    end
    if (w_nan_a || w_nan_b) begin
      w_res = 32'h7FC0_0000;
    end else if (w_inf_a || w_inf_b) begin
      w_res = (w_zero_a || w_zero_b) ? 32'h7FC0_0000 : {w_sign, 8'hFF, 23'd0};
    end else if (w_zero_a || w_zero_b) begin
      w_res = {w_sign, 31'd0};
    end else if (w_exp >= 10'sd255) begin
      w_res = {w_sign, 8'hFF, 23'd0};
    end else if (w_exp <= 10'sd0) begin
      w_res = {w_sign, 31'd0};
    end else begin
      w_res = {w_sign, w_exp[7:0], w_mant[22:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_y <= '0;
    end else if (i_en) begin
      o_y <= w_res;
    end
  end

endmodule

// File: rtl/fmul_sched.sv
// Two-port scheduler in front of a single shared fmul: arbitrates one issue per cycle,
// tracks the in-flight op by port tag and parks each result in a per-port buffer.
module fmul_sched
  import fmul_sched_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NumPorts-1:0] req_valid,
  output logic [NumPorts-1:0] req_ready,
  input  logic [FloatW-1:0]   req_x1_0,
  input  logic [FloatW-1:0]   req_x2_0,
  input  logic [FloatW-1:0]   req_x1_1,
  input  logic [FloatW-1:0]   req_x2_1,
  output logic [NumPorts-1:0] resp_valid,
  input  logic [NumPorts-1:0] resp_ready,
  output logic [FloatW-1:0]   resp_y_0,
  output logic [FloatW-1:0]   resp_y_1,
  output logic                busy,
  output logic [31:0]         issue_cnt
);

  logic                r_inflight;
  port_id_t            r_tag;
  port_id_t            r_last;
  logic [NumPorts-1:0] r_buf_vld;
  logic [FloatW-1:0]   r_buf_y [NumPorts];
  logic [31:0]         r_issue_cnt;

  logic [NumPorts-1:0] w_drain, w_elig, w_cand;
  port_id_t            w_gnt_id;
  logic                w_acc;
  logic [FloatW-1:0]   w_x1, w_x2, w_y;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      w_drain[p] = r_buf_vld[p] & resp_ready[p];
      w_elig[p]  = !(r_inflight && (r_tag == port_id_t'(p))) && (!r_buf_vld[p] || w_drain[p]);
    end
    w_cand = rst ? '0 : (req_valid & w_elig);
    if (w_cand == 2'b11) begin
      w_gnt_id = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
    end else begin
      w_gnt_id = w_cand[1];
    end
    w_acc     = |w_cand;
    req_ready = w_acc ? (2'b01 << w_gnt_id) : 2'b00;
  end

  assign w_x1 = w_gnt_id[0] ? req_x1_1 : req_x1_0;
  assign w_x2 = w_gnt_id[0] ? req_x2_1 : req_x2_0;

  fmul_sched_fmul u_fmul (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_acc),
    .i_x1 (w_x1),
    .i_x2 (w_x2),
    .o_y  (w_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight  <= 1'b0;
      r_tag       <= '0;
      r_last      <= 1'b1;
      r_issue_cnt <= '0;
    end else begin
      r_inflight <= w_acc;
      if (w_acc) begin
        r_tag       <= w_gnt_id;
        r_last      <= w_gnt_id;
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
    end
  end

  // A landing result takes priority; it also covers drain-and-refill at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_vld <= '0;
      r_buf_y   <= '{default: '0};
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (r_inflight && (r_tag == port_id_t'(p))) begin
          r_buf_vld[p] <= 1'b1;
          r_buf_y[p]   <= w_y;
        end else if (w_drain[p]) begin
          r_buf_vld[p] <= 1'b0;
        end
      end
    end
  end

  assign resp_valid = r_buf_vld;
  assign resp_y_0   = r_buf_y[0];
  assign resp_y_1   = r_buf_y[1];
  assign busy       = r_inflight | (|r_buf_vld);
  assign issue_cnt  = r_issue_cnt;

endmodule

// File: tb/tb_fmul_sched.sv
// Drives a round-robin and a fixed-priority fmul_sched with identical stimulus and checks
// both against a per-port reference model (one pending item each, with an arrival cycle).
module tb_fmul_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, resp_ready;
  logic [31:0] x1_0, x2_0, x1_1, x2_1;

  logic [1:0]  w_req_ready  [2];
  logic [1:0]  w_resp_valid [2];
  logic [31:0] w_y0 [2];
  logic [31:0] w_y1 [2];
  logic [31:0] w_cnt [2];
  logic        w_busy [2];

  always #5 clk = ~clk;

  fmul_sched #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w_req_ready[0]),
    .req_x1_0(x1_0), .req_x2_0(x2_0), .req_x1_1(x1_1), .req_x2_1(x2_1),
    .resp_valid(w_resp_valid[0]), .resp_ready(resp_ready),
    .resp_y_0(w_y0[0]), .resp_y_1(w_y1[0]), .busy(w_busy[0]), .issue_cnt(w_cnt[0])
  );

  fmul_sched #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w_req_ready[1]),
    .req_x1_0(x1_0), .req_x2_0(x2_0), .req_x1_1(x1_1), .req_x2_1(x2_1),
    .resp_valid(w_resp_valid[1]), .resp_ready(resp_ready),
    .resp_y_0(w_y0[1]), .resp_y_1(w_y1[1]), .busy(w_busy[1]), .issue_cnt(w_cnt[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference state, [instance][port]: instance 0 round-robin, instance 1 fixed priority.
  bit          m_has   [2][2];
  logic [31:0] m_val   [2][2];
  int          m_avail [2][2];
  bit          m_last  [2];
  logic [31:0] m_cnt   [2];

  logic [31:0] ops [10] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4000_0000, 32'hC000_0000,
                            32'h3F00_0000, 32'h4040_0000, 32'hBF40_0000, 32'h3FA0_0000,
                            32'h0000_0000, 32'h4120_0000};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic real f_to_r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r_to_f(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
    return r_to_f(f_to_r(a) * f_to_r(b));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) m_has[i][p] = 1'b0;
      m_last[i] = 1'b1;
      m_cnt[i]  = '0;
    end
  endtask

  // Called just after a falling edge with inputs already driven; checks, then advances one edge.
  task automatic step();
    logic [1:0] cand, exp_rv, exp_rdy;
    int         g;
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        exp_rv[p] = m_has[i][p] && (m_avail[i][p] <= cyc);
        cand[p]   = req_valid[p] && (!m_has[i][p] || (exp_rv[p] && resp_ready[p]));
      end
      if (cand == 2'b11) g = (i == 1) ? 0 : (m_last[i] ? 0 : 1);
      else g = cand[1] ? 1 : 0;
      exp_rdy = (cand != 2'b00) ? 2'(1 << g) : 2'b00;
      check_eq($sformatf("req_ready[%0d]", i), 32'(w_req_ready[i]), 32'(exp_rdy));
      check_eq($sformatf("resp_valid[%0d]", i), 32'(w_resp_valid[i]), 32'(exp_rv));
      check_eq($sformatf("busy[%0d]", i), 32'(w_busy[i]), 32'(m_has[i][0] | m_has[i][1]));
      check_eq($sformatf("issue_cnt[%0d]", i), w_cnt[i], m_cnt[i]);
      if (exp_rv[0]) check_eq($sformatf("resp_y_0[%0d]", i), w_y0[i], m_val[i][0]);
      if (exp_rv[1]) check_eq($sformatf("resp_y_1[%0d]", i), w_y1[i], m_val[i][1]);
      for (int p = 0; p < 2; p++) if (exp_rv[p] && resp_ready[p]) m_has[i][p] = 1'b0;
      if (cand != 2'b00) begin
        m_has[i][g]   = 1'b1;
        m_val[i][g]   = (g == 1) ? f_mul(x1_1, x2_1) : f_mul(x1_0, x2_0);
        m_avail[i][g] = cyc + 2;
        m_last[i]     = (g == 1);
        m_cnt[i]      = m_cnt[i] + 32'd1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq({tag, "_rdy"}, 32'(w_req_ready[i]), 32'd0);
      check_eq({tag, "_rv"}, 32'(w_resp_valid[i]), 32'd0);
      check_eq({tag, "_y0"}, w_y0[i], 32'd0);
      check_eq({tag, "_y1"}, w_y1[i], 32'd0);
      check_eq({tag, "_busy"}, 32'(w_busy[i]), 32'd0);
      check_eq({tag, "_cnt"}, w_cnt[i], 32'd0);
    end
  endtask

  logic [31:0] cnt_before, y1_held;

  initial begin
    rst = 1'b1; req_valid = 2'b11; resp_ready = 2'b11;
    x1_0 = '0; x2_0 = '0; x1_1 = '0; x2_1 = '0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;

    // Single multiply on port 0.
    req_valid = 2'b01; x1_0 = 32'h3FC0_0000; x2_0 = 32'h4000_0000;
    step();
    req_valid = 2'b00;
    step();
    check_eq("single_y0", w_y0[0], 32'h4040_0000);
    check_eq("single_rv", 32'(w_resp_valid[0]), 32'd1);
    check_eq("single_cnt", w_cnt[0], 32'd1);
    step();

    // Both ports streaming with outputs always accepted.
    x1_0 = 32'h3F80_0000; x2_0 = 32'h3F80_0000; x1_1 = 32'hC000_0000; x2_1 = 32'h3F00_0000;
    req_valid = 2'b11;
    cnt_before = w_cnt[0];
    for (int k = 0; k < 8; k++) step();
    check_eq("stream_rate", w_cnt[0] - cnt_before, 32'd8);
    check_eq("stream_y0", w_y0[0], 32'h3F80_0000);
    check_eq("stream_y1", w_y1[0], 32'hBF80_0000);

    // Port 1 output stalled while both keep requesting.
    resp_ready = 2'b01;
    step();
    step();
    y1_held = w_y1[0];
    for (int k = 0; k < 4; k++) step();
    check_eq("stall_y1_stable", w_y1[0], y1_held);
    resp_ready = 2'b11;
    for (int k = 0; k < 3; k++) step();

    // Reset the cycle after an accept.
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) step();
    req_valid = 2'b01; x1_0 = 32'h4040_0000; x2_0 = 32'h3FA0_0000;
    step();
    rst = 1'b1; req_valid = 2'b11;
    check_reset_outputs("midop");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;
    for (int k = 0; k < 4; k++) step();
    check_eq("midop_no_resp", 32'(w_resp_valid[0]), 32'd0);

    // Counter wrap.
    force u_rr.r_issue_cnt = 32'hFFFF_FFFF;
    #1;
    release u_rr.r_issue_cnt;
    m_cnt[0] = 32'hFFFF_FFFF;
    req_valid = 2'b01;
    step();
    check_eq("wrap_cnt", w_cnt[0], 32'd0);
    req_valid = 2'b00;
    step();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      req_valid     = 2'($urandom_range(0, 3));
      resp_ready[0] = ($urandom_range(0, 3) != 0);
      resp_ready[1] = ($urandom_range(0, 3) != 0);
      x1_0 = ops[$urandom_range(0, 9)];
      x2_0 = ops[$urandom_range(0, 9)];
      x1_1 = ops[$urandom_range(0, 9)];
      x2_1 = ops[$urandom_range(0, 9)];
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
